// File: rtl/jpeg_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jpeg_mem_pkg                                                         |
// | Shared types for the JPEG decoder's on-chip RAM access path:         |
// | arbiter state encoding, the request field layout and a wrap helper.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package jpeg_mem_pkg;

  localparam int JPEG_MEM_ADDRESS_WIDTH = 16;
  localparam int JPEG_MEM_DATA_WIDTH    = 8;

  // Arbiter modes: plain round-robin, or port held by one owner.
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // One requester's access as seen on the RAM pins.
  typedef struct packed {
    logic                              we;
    logic [JPEG_MEM_ADDRESS_WIDTH-1:0] addr;
    logic [JPEG_MEM_DATA_WIDTH-1:0]    wdata;
  } ram_req_t;

  // (idx + 1) mod n without a divider.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Combinational round-robin priority picker. Selects the first set     |
// | bit of req at or after rr_ptr, wrapping modulo NUM_REQ.              |
// | Ports: req (requests), rr_ptr (search start) -> gnt (one-hot),       |
// |        index (binary of gnt), valid (any request present).           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_WIDTH-1:0] index,
  output logic                 valid
);

  always_comb begin
    gnt   = '0;
    index = '0;
    valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!valid && req[(int'(rr_ptr) + off) % NUM_REQ]) begin
        gnt[(int'(rr_ptr) + off) % NUM_REQ] = 1'b1;
        index = IDX_WIDTH'((int'(rr_ptr) + off) % NUM_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_port_arbiter                                                     |
// | Shares one single-port synchronous RAM between NUM_REQ requesters.   |
// | Round-robin when idle; a granted access with lock=1 keeps the port   |
// | for its owner for at most MAX_LOCK consecutive grants.               |
// | Ports: req/lock/we/addr/wdata per requester in; gnt one-hot out;     |
// |        rvalid/rdata read return; ram_* drive the external RAM pins.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module ram_port_arbiter
  import jpeg_mem_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 16,
  parameter int MAX_LOCK      = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               lock,
  input  logic [NUM_REQ-1:0]               we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             ram_ce,
  output logic                             ram_we,
  output logic [ADDRESS_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]            ram_data_input,
  input  logic [DATA_WIDTH-1:0]            ram_data_output
);

  localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_WIDTH = $clog2(MAX_LOCK + 1);

  arb_state_t            r_state;
  logic [IDX_WIDTH-1:0]  r_rr_ptr;
  logic [IDX_WIDTH-1:0]  r_owner;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;
  logic [NUM_REQ-1:0]    r_rvalid;

  logic [NUM_REQ-1:0]    w_pick_gnt;
  logic [IDX_WIDTH-1:0]  w_pick_idx;
  logic                  w_pick_valid;
  logic                  w_owner_active;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_WIDTH-1:0]  w_idx;
  logic                  w_any;
  logic [IDX_WIDTH-1:0]  w_next_ptr;

  rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .gnt    (w_pick_gnt),
    .index  (w_pick_idx),
    .valid  (w_pick_valid)
  );

  // The owner keeps the port only while it is still requesting; otherwise
  // this same cycle is arbitrated round-robin.
  assign w_owner_active = !rst && (r_state == ARB_OWNED) && req[r_owner];

  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    if (rst) begin
      w_any = 1'b0;
    end else if (w_owner_active) begin
      w_gnt[r_owner] = 1'b1;
      w_idx          = r_owner;
      w_any          = 1'b1;
    end else if (w_pick_valid) begin
      w_gnt = w_pick_gnt;
      w_idx = w_pick_idx;
      w_any = 1'b1;
    end
  end

  // On an owned grant w_idx equals r_owner, so one expression serves both
  // the round-robin advance and the release pointer.
  assign w_next_ptr = IDX_WIDTH'(next_index(int'(w_idx), NUM_REQ));

  assign gnt            = w_gnt;
  assign ram_ce         = w_any;
  assign ram_we         = w_any & we[w_idx];
  assign ram_address    = w_any ? addr[int'(w_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
  assign ram_data_input = w_any ? wdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign rvalid         = r_rvalid;
  // The RAM's own output register is the read pipeline stage.
  assign rdata          = ram_data_output;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_rvalid   <= '0;
    end else begin
      r_rvalid <= w_gnt & ~we;
      if (w_owner_active) begin
        // Release on lock=0, or when this grant is the MAX_LOCK-th in a row.
        if (lock[r_owner] && (int'(r_hold_cnt) + 1 < MAX_LOCK)) begin
          r_hold_cnt <= r_hold_cnt + HOLD_WIDTH'(1);
        end else begin
          r_state    <= ARB_IDLE;
          r_rr_ptr   <= w_next_ptr;
          r_hold_cnt <= '0;
        end
      end else if (w_any) begin
        r_rr_ptr <= w_next_ptr;
        if (lock[w_idx] && (MAX_LOCK > 1)) begin
          r_state    <= ARB_OWNED;
          r_owner    <= w_idx;
          r_hold_cnt <= HOLD_WIDTH'(1);
        end else begin
          r_state    <= ARB_IDLE;
          r_hold_cnt <= '0;
        end
      end else if (r_state == ARB_OWNED) begin
        // Owner stopped requesting and nobody else is: drop ownership.
        r_state    <= ARB_IDLE;
        r_hold_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_port_arbiter                                                  |
// | Self-checking bench: a 2-requester arbiter (MAX_LOCK=64) and a       |
// | 4-requester arbiter (MAX_LOCK=4), each with a bench RAM, checked     |
// | against a behavioural model under directed and random traffic.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_ram_port_arbiter;
  import jpeg_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;
  always #5 clk = ~clk;

  int n_of[2]  = '{2, 4};
  int ml_of[2] = '{64, 4};

  // Stimulus, per instance and requester.
  logic [7:0]    s_req[2];
  logic [7:0]    s_lock[2];
  logic [7:0]    s_we[2];
  logic [AW-1:0] s_addr[2][8];
  logic [DW-1:0] s_wd[2][8];

  // Instance 0 wiring.
  logic [1:0]      d0_gnt, d0_rvalid;
  logic [2*AW-1:0] d0_addr;
  logic [2*DW-1:0] d0_wdata;
  logic [DW-1:0]   d0_rdata, d0_di, d0_do;
  logic [AW-1:0]   d0_ad;
  logic            d0_ce, d0_rwe;
  // Instance 1 wiring.
  logic [3:0]      d1_gnt, d1_rvalid;
  logic [4*AW-1:0] d1_addr;
  logic [4*DW-1:0] d1_wdata;
  logic [DW-1:0]   d1_rdata, d1_di, d1_do;
  logic [AW-1:0]   d1_ad;
  logic            d1_ce, d1_rwe;

  always_comb begin
    d0_addr = '0; d0_wdata = '0; d1_addr = '0; d1_wdata = '0;
    for (int r = 0; r < 2; r++) begin
      d0_addr[r*AW +: AW]  = s_addr[0][r];
      d0_wdata[r*DW +: DW] = s_wd[0][r];
    end
    for (int r = 0; r < 4; r++) begin
      d1_addr[r*AW +: AW]  = s_addr[1][r];
      d1_wdata[r*DW +: DW] = s_wd[1][r];
    end
  end

  ram_port_arbiter #(.NUM_REQ(2), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_LOCK(64)) dut (
    .clk(clk), .rst(rst), .req(s_req[0][1:0]), .lock(s_lock[0][1:0]), .we(s_we[0][1:0]),
    .addr(d0_addr), .wdata(d0_wdata), .gnt(d0_gnt), .rvalid(d0_rvalid), .rdata(d0_rdata),
    .ram_ce(d0_ce), .ram_we(d0_rwe), .ram_address(d0_ad), .ram_data_input(d0_di),
    .ram_data_output(d0_do));

  ram_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_LOCK(4)) dut4 (
    .clk(clk), .rst(rst), .req(s_req[1][3:0]), .lock(s_lock[1][3:0]), .we(s_we[1][3:0]),
    .addr(d1_addr), .wdata(d1_wdata), .gnt(d1_gnt), .rvalid(d1_rvalid), .rdata(d1_rdata),
    .ram_ce(d1_ce), .ram_we(d1_rwe), .ram_address(d1_ad), .ram_data_input(d1_di),
    .ram_data_output(d1_do));

  // Bench RAMs: 32 words, one-cycle read latency, output register cleared by rst.
  logic [DW-1:0] ram0[32];
  logic [DW-1:0] ram1[32];
  always @(posedge clk) begin
    if (ram_clr) for (int k = 0; k < 32; k++) begin ram0[k] <= '0; ram1[k] <= '0; end
    if (rst) begin
      d0_do <= '0;
      d1_do <= '0;
    end else begin
      if (d0_ce) begin
        if (d0_rwe) ram0[d0_ad[4:0]] <= d0_di; else d0_do <= ram0[d0_ad[4:0]];
      end
      if (d1_ce) begin
        if (d1_rwe) ram1[d1_ad[4:0]] <= d1_di; else d1_do <= ram1[d1_ad[4:0]];
      end
    end
  end

  // Normalised views of both instances.
  logic [7:0]    o_gnt[2], o_rv[2];
  logic [DW-1:0] o_rd[2], o_di[2];
  logic [AW-1:0] o_ad[2];
  logic          o_ce[2], o_we[2];
  assign o_gnt[0] = {6'b0, d0_gnt};  assign o_gnt[1] = {4'b0, d1_gnt};
  assign o_rv[0]  = {6'b0, d0_rvalid}; assign o_rv[1] = {4'b0, d1_rvalid};
  assign o_rd[0]  = d0_rdata; assign o_rd[1] = d1_rdata;
  assign o_di[0]  = d0_di;    assign o_di[1] = d1_di;
  assign o_ad[0]  = d0_ad;    assign o_ad[1] = d1_ad;
  assign o_ce[0]  = d0_ce;    assign o_ce[1] = d1_ce;
  assign o_we[0]  = d0_rwe;   assign o_we[1] = d1_rwe;

  // Reference model: owner (-1 = none), pointer, consecutive-grant count,
  // expected rvalid/rdata for the current cycle, and memory contents.
  int            m_owner[2], m_ptr[2], m_hold[2];
  logic [7:0]    m_rv[2];
  logic [DW-1:0] m_rd[2];
  logic [DW-1:0] m_mem[2][32];

  int            grant_idx[2];
  logic [7:0]    cap_gnt[2], cap_rv[2];
  logic [DW-1:0] cap_rd[2];
  logic          cap_ce[2];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int i);
    if (rst) return -1;
    if (m_owner[i] >= 0 && s_req[i][m_owner[i]]) return m_owner[i];
    for (int off = 0; off < n_of[i]; off++)
      if (s_req[i][(m_ptr[i] + off) % n_of[i]]) return (m_ptr[i] + off) % n_of[i];
    return -1;
  endfunction

  task automatic update(input int i, input int g);
    if (rst) begin
      m_owner[i] = -1; m_ptr[i] = 0; m_hold[i] = 0; m_rv[i] = '0; m_rd[i] = '0;
      return;
    end
    m_rv[i] = '0;
    if (g < 0) begin
      m_owner[i] = -1;
      return;
    end
    if (s_we[i][g]) m_mem[i][s_addr[i][g][4:0]] = s_wd[i][g];
    else begin
      m_rd[i] = m_mem[i][s_addr[i][g][4:0]];
      m_rv[i] = 8'(1 << g);
    end
    if (m_owner[i] == g) begin
      if (s_lock[i][g]) m_hold[i]++;
      if (!s_lock[i][g] || m_hold[i] >= ml_of[i]) begin
        m_owner[i] = -1; m_hold[i] = 0; m_ptr[i] = (g + 1) % n_of[i];
      end
    end else begin
      m_ptr[i] = (g + 1) % n_of[i];
      if (s_lock[i][g] && ml_of[i] > 1) begin m_owner[i] = g; m_hold[i] = 1; end
      else begin m_owner[i] = -1; m_hold[i] = 0; end
    end
  endtask

  // One clock: inputs already applied at the falling edge.
  task automatic cycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      int g;
      g = pick(i);
      cap_gnt[i] = o_gnt[i]; cap_rv[i] = o_rv[i]; cap_rd[i] = o_rd[i]; cap_ce[i] = o_ce[i];
      check($sformatf("gnt[%0d]", i), o_gnt[i], (g >= 0) ? 32'(1 << g) : 32'h0);
      check($sformatf("ram_ce[%0d]", i), o_ce[i], g >= 0);
      check($sformatf("ram_we[%0d]", i), o_we[i], (g >= 0) ? s_we[i][g] : 1'b0);
      check($sformatf("ram_addr[%0d]", i), o_ad[i], (g >= 0) ? s_addr[i][g] : '0);
      check($sformatf("ram_din[%0d]", i), o_di[i], (g >= 0) ? s_wd[i][g] : '0);
      check($sformatf("rvalid[%0d]", i), o_rv[i], m_rv[i]);
      check($sformatf("rdata[%0d]", i), o_rd[i], m_rd[i]);
      update(i, g);
      grant_idx[i] = g;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ram_req_t mk(input bit w, input int a, input int d);
    ram_req_t rq;
    rq.we = w; rq.addr = AW'(a); rq.wdata = DW'(d);
    return rq;
  endfunction

  task automatic set_req(input int i, input int r, input bit en, input bit lk, input ram_req_t rq);
    s_req[i][r] = en; s_lock[i][r] = lk; s_we[i][r] = rq.we;
    s_addr[i][r] = rq.addr; s_wd[i][r] = rq.wdata;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      s_req[i] = '0; s_lock[i] = '0;
    end
  endtask

  // Random traffic; a pending, ungranted request is held stable.
  task automatic gen(input int i);
    for (int r = 0; r < n_of[i]; r++) begin
      if (!s_req[i][r] || grant_idx[i] == r)
        set_req(i, r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                mk(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 255)));
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] prev;
    for (int i = 0; i < 2; i++) begin
      s_req[i] = '0; s_lock[i] = '0; s_we[i] = '0;
      for (int r = 0; r < 8; r++) begin s_addr[i][r] = '0; s_wd[i][r] = '0; end
      m_owner[i] = -1; m_ptr[i] = 0; m_hold[i] = 0; m_rv[i] = '0; m_rd[i] = '0;
      grant_idx[i] = -1;
      for (int k = 0; k < 32; k++) m_mem[i][k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_clr = 1'b0;
    cycle();                                  // still in reset: gnt/ce must be 0
    rst = 1'b0;

    // Write 0xA5 to 0x0010 from requester 0, read it back via requester 1.
    set_req(0, 0, 1, 0, mk(1, 'h10, 'hA5)); cycle();
    check("wr_gnt", cap_gnt[0], 8'h01);
    idle_all(); set_req(0, 1, 1, 0, mk(0, 'h10, 0)); cycle();
    check("rd_gnt", cap_gnt[0], 8'h02);
    idle_all(); cycle();
    check("rd_rvalid", cap_rv[0], 8'h02);
    check("rd_data", cap_rd[0], 8'hA5);

    // Both requesters reading, no lock: strict alternation.
    set_req(0, 0, 1, 0, mk(0, 'h10, 0)); set_req(0, 1, 1, 0, mk(0, 'h10, 0));
    prev = 8'h00;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_alt", cap_gnt[0], (k % 2 == 0) ? 8'h01 : 8'h02);
      check("rr_rvalid", cap_rv[0], prev);
      prev = (k % 2 == 0) ? 8'h01 : 8'h02;
    end
    idle_all(); cycle();

    // Requester 1 locks continuously against a waiting requester 0.
    set_req(0, 1, 1, 1, mk(0, 'h03, 0)); cycle();
    cnt = (cap_gnt[0] == 8'h02) ? 1 : 0;
    set_req(0, 0, 1, 0, mk(0, 'h04, 0));
    for (int k = 0; k < 100 && cap_gnt[0] == 8'h02; k++) begin
      cycle();
      if (cap_gnt[0] == 8'h02) cnt++;
    end
    check("lock_burst_len", cnt, 64);
    check("after_burst", cap_gnt[0], 8'h01);
    idle_all(); cycle();

    // Owner 0 drops req for one cycle; requester 1 wins that same cycle.
    set_req(0, 0, 1, 1, mk(0, 'h05, 0)); cycle();
    set_req(0, 1, 1, 1, mk(0, 'h06, 0)); cycle();
    check("own_hold", cap_gnt[0], 8'h01);
    s_req[0][0] = 1'b0; cycle();
    check("drop_fallback", cap_gnt[0], 8'h02);
    set_req(0, 0, 1, 0, mk(0, 'h07, 0)); s_lock[0][1] = 1'b0; cycle();
    check("new_owner", cap_gnt[0], 8'h02);
    idle_all(); cycle();

    // Reset in the middle of a locked read burst.
    set_req(0, 0, 1, 1, mk(0, 'h10, 0)); cycle(); cycle();
    rst = 1'b1; cycle();
    check("rst_gnt", cap_gnt[0], 8'h00);
    check("rst_ce", cap_ce[0], 1'b0);
    cycle();
    check("rst_rvalid", cap_rv[0], 8'h00);
    rst = 1'b0;
    set_req(0, 0, 1, 0, mk(0, 'h10, 0)); set_req(0, 1, 1, 0, mk(0, 'h11, 0)); cycle();
    check("post_rst_prio", cap_gnt[0], 8'h01);
    idle_all(); cycle();

    // Four requesters, req=1010 with pointer moved to 2.
    set_req(1, 1, 1, 0, mk(0, 'h01, 0)); cycle();
    set_req(1, 3, 1, 0, mk(0, 'h02, 0));
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("rr4", cap_gnt[1], (k % 2 == 0) ? 8'h08 : 8'h02);
    end
    idle_all(); cycle();

    // Random traffic on both instances with occasional reset pulses.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      gen(0);
      gen(1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
